vga_tile_renderer: RTL and testbench
====================================

Name: vga_tile_renderer

Overview:
- Read side of the 40x30 tile map RAM.
- Generates 640x480@60 VGA timing and derives the tile address for each pixel, which drives the RAM's VGA read port.
- Takes back the 3-bit tile code returned one clock later and expands it through a fixed palette and sub-tile pattern into 8-bit RGB (3:3:2).
- Outputs sync, blank and a per-frame tick for game logic; all of these are delay-matched to the pixel data.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- MAP_W, 40, tiles per map row (tile size is fixed at 16x16)

Ports:
- clk  input  1  pixel clock (25 MHz); one pixel per cycle
- rst  input  1  asynchronous, active-high reset
- addr_vga  output  11  tile RAM read address, registered
- dout_vga  input  3  tile code from RAM; valid one clk after addr_vga
- rgb  output  8  pixel colour {R[2:0],G[2:0],B[1:0]}, registered
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- blank  output  1  high outside the visible area
- frame_tick  output  1  one-cycle pulse at the start of vertical blank

Behaviour:
- Reset (async, rst=1):
  - hc=0, vc=0, addr_vga=0, rgb=0, blank=1, hsync=1, vsync=1, frame_tick=0, all pipeline registers cleared.
  - Counting starts on the first clk edge after rst deasserts.
  - Reset asserted mid-frame forces these values immediately; the frame restarts at (0,0).
- Counters:
  - hc runs 0..799 and wraps to 0. vc increments when hc wraps, runs 0..524, and wraps to 0.
  - Totals are H_VIS+H_FP+H_SYNC+H_BP and V_VIS+V_FP+V_SYNC+V_BP.
- Stage 0 (counters):
  - vis0 = (hc<H_VIS)&&(vc<V_VIS).
  - hs0 is active (low) for hc in 656..751; vs0 is active (low) for vc in 490..491.
- Stage 1 (one registered cycle):
  - addr_vga <= vis0 ? (vc[8:4]*MAP_W + hc[9:4]) : 0.
  - The multiply is implemented as (row<<5)+(row<<3); the result is 11 bits, maximum 1199.
  - Sub-tile offsets hc[3:0] and vc[3:0] are registered together with vis, hs and vs.
- Stage 2: the RAM returns dout_vga. Offsets, vis, hs and vs are delayed one more cycle.
- Stage 3 (registered output): rgb is decoded from dout_vga and the stage-2 offsets (ox, oy).
  - If blanked: rgb=0x00.
  - 0 empty -> 0x00.
  - 1 wall -> 0x03.
  - 2 dot -> 0xFF when ox and oy are both in 6..9, else 0x00.
  - 3 power pellet -> 0xFF when ox and oy are both in 4..11, else 0x00.
  - 4 pac-man -> 0xFC.
  - 5 ghost -> 0xE0.
  - 6 ghost door -> 0xF3 when oy is in 7..8, else 0x00.
  - 7 -> 0x1C.
- Output alignment: hsync, vsync and blank are registered in the same stage as rgb.
  - Counter state (hc,vc) at cycle c appears on rgb/hsync/vsync/blank at cycle c+3.
  - All outputs share this 3-cycle latency.
- frame_tick:
  - High for exactly one clk, 3 cycles after the counters reach (hc=0, vc=480).
  - Aligned with the first blanked output of vertical blank; it is 0 otherwise.
- Boundary conditions:
  - hc=639 -> 640 gives the last visible pixel, then blank.
  - vc wrap 524 -> 0 resumes visible output without a glitch.
  - addr_vga stays 0 throughout blanking.
  - Tile column 39 and row 29 are the last addressed (address 1199).
- The block only reads. It imposes no constraint on game-logic RAM writes; a write to a cell shows from the next read of that cell.

Test Plan:
- Reset release: hold rst 5 cycles, release -> during reset rgb=0, hsync=vsync=1, blank=1; after release blank deasserts 3 cycles later; first addr_vga=0.
- Addressing: at hc=17, vc=35 -> addr_vga=2*40+1=81 on the next cycle. At hc=639, vc=479 -> addr_vga=1199.
- Sync timing: measure over one frame -> hsync low for 96 clks starting 659 cycles after visible line start (656+3); line period 800. vsync low for 2 lines from line 490; frame period 420000 clks.
- Palette and pattern (RAM model with 1-cycle read latency, tile 0 = code 2, tile 1 = code 1):
  - tile 0 -> rgb=0xFF only for pixels x,y in 6..9, else 0x00.
  - tile 1 -> 0x03 across all 16x16 pixels.
  - code 6 -> 0xF3 only on rows 7..8.
- frame_tick: run 2 frames -> exactly 2 single-cycle pulses, 420000 clks apart, each coincident with the first blank=1 output of line 480.
- Mid-frame reset: assert rst at hc=300, vc=200 -> outputs return to reset values immediately; the next frame starts at (0,0); frame_tick does not fire early.

Source files
------------

// File: rtl/vga_tile_renderer.sv
// VGA read side of the 40x30 tile map: 640x480@60 timing, tile address generation,
// and 3-stage pixel pipeline expanding tile codes into RGB332 with delay-matched syncs.
module vga_tile_renderer #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int MAP_W  = 40
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] addr_vga,
  input  logic [2:0]  dout_vga,
  output logic [7:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_tick
);
  localparam int STAGES = 2;
  localparam logic [9:0] HV     = 10'(H_VIS);
  localparam logic [9:0] HS_B   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VV     = 10'(V_VIS);
  localparam logic [9:0] VS_B   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  // Sideband travelling alongside the RAM access; hs/vs are active-high here.
  typedef struct packed {
    logic [3:0] ox;
    logic [3:0] oy;
    logic       hs;
    logic       vs;
    logic       ft;
  } side_t;

  logic [9:0]        hc, vc;
  logic              vis0;
  side_t             s0;
  side_t             s1, s2;
  logic [STAGES:1]   vld_pipe;
  logic [4:0]        row;
  logic [5:0]        col;
  logic [10:0]       row_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  always_comb begin
    vis0  = (hc < HV) && (vc < VV);
    s0    = '0;
    s0.ox = hc[3:0];
    s0.oy = vc[3:0];
    s0.hs = (hc >= HS_B) && (hc < HS_E);
    s0.vs = (vc >= VS_B) && (vc < VS_E);
    s0.ft = (hc == 10'd0) && (vc == VV);
  end

  assign row = vc[8:4];
  assign col = hc[9:4];
  // Row*40 as two shifts; the generic multiply only exists for other map widths.
  assign row_base = (MAP_W == 40) ? ({1'b0, row, 5'b0} + {3'b0, row, 3'b0})
                                  : 11'(row * MAP_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_vga <= '0;
      s1       <= '0;
      s2       <= '0;
      vld_pipe <= '0;
    end else begin
      addr_vga <= vis0 ? (row_base + {5'b0, col}) : 11'd0;
      s1       <= s0;
      s2       <= s1;
      vld_pipe <= {vld_pipe[STAGES-1:1], vis0};
    end
  end

  function automatic logic [7:0] palette(input logic [2:0] code,
                                         input logic [3:0] ox,
                                         input logic [3:0] oy);
    logic [7:0] c;
    c = 8'h00;
    case (code)
      3'd0: c = 8'h00;
      3'd1: c = 8'h03;
      3'd2: c = (ox >= 4'd6 && ox <= 4'd9 && oy >= 4'd6 && oy <= 4'd9) ? 8'hFF : 8'h00;
      3'd3: c = (ox >= 4'd4 && ox <= 4'd11 && oy >= 4'd4 && oy <= 4'd11) ? 8'hFF : 8'h00;
      3'd4: c = 8'hFC;
      3'd5: c = 8'hE0;
      3'd6: c = (oy == 4'd7 || oy == 4'd8) ? 8'hF3 : 8'h00;
      3'd7: c = 8'h1C;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb        <= 8'h00;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= vld_pipe[STAGES] ? palette(dout_vga, s2.ox, s2.oy) : 8'h00;
      hsync      <= ~s2.hs;
      vsync      <= ~s2.vs;
      blank      <= ~vld_pipe[STAGES];
      frame_tick <= s2.ft;
    end
  end
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench: random tile map behind a 1-cycle RAM, outputs compared every cycle
// against a frame-position model; vertical timing shortened so whole frames fit the run.
module tb_vga_tile_renderer;
  localparam int VV = 20, VF = 2, VS = 2, VB = 2;
  localparam int HT = 800, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr_vga;
  logic [2:0]  dout_vga = 3'd0;
  logic [7:0]  rgb;
  logic        hsync, vsync, blank, frame_tick;

  vga_tile_renderer #(.V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst(rst), .addr_vga(addr_vga), .dout_vga(dout_vga), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  logic [2:0] mem [0:1199];
  always @(posedge clk) dout_vga <= (addr_vga < 11'd1200) ? mem[addr_vga] : 3'd0;

  int n = 0, cyc = 0;
  int total = 0, bad = 0;
  int tick_cnt = 0;
  int tick_t [0:7];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    n   <= rst ? 0 : n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic int pat(input int code, input int ox, input int oy);
    case (code)
      1: return 'h03;
      2: return (ox >= 6 && ox <= 9 && oy >= 6 && oy <= 9) ? 'hFF : 0;
      3: return (ox >= 4 && ox <= 11 && oy >= 4 && oy <= 11) ? 'hFF : 0;
      4: return 'hFC;
      5: return 'hE0;
      6: return (oy == 7 || oy == 8) ? 'hF3 : 0;
      7: return 'h1C;
      default: return 0;
    endcase
  endfunction

  // k = clock edges since reset release; counter position at edge k equals k in raster order.
  task automatic model(input int k, output int e_addr, output int e_rgb, output int e_hs,
                       output int e_vs, output int e_bl, output int e_ft);
    int s, h, v;
    e_addr = 0;
    if (k >= 1) begin
      s = k - 1; h = s % HT; v = (s / HT) % VT;
      if (h < 640 && v < VV) e_addr = (v / 16) * 40 + h / 16;
    end
    e_rgb = 0; e_hs = 1; e_vs = 1; e_bl = 1; e_ft = 0;
    if (k >= 3) begin
      s = k - 3; h = s % HT; v = (s / HT) % VT;
      if (h < 640 && v < VV) begin
        e_bl  = 0;
        e_rgb = pat(int'(mem[(v / 16) * 40 + h / 16]), h % 16, v % 16);
      end
      e_hs = (h >= 656 && h < 752) ? 0 : 1;
      e_vs = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
      e_ft = (h == 0 && v == VV) ? 1 : 0;
    end
  endtask

  always @(negedge clk) begin
    int ea, er, eh, ev, eb, ef;
    if (rst) begin
      model(0, ea, er, eh, ev, eb, ef);
    end else begin
      model(n, ea, er, eh, ev, eb, ef);
      if (frame_tick && tick_cnt < 8) begin
        tick_t[tick_cnt] = cyc;
        tick_cnt++;
      end
      if (n == 3)                  chk("first_visible_blank", int'(blank), 0);
      if (n == 658)                chk("hsync_before", int'(hsync), 1);
      if (n == 659)                chk("hsync_start", int'(hsync), 0);
      if (n == 1 + 19*HT + 17)     chk("addr_r1c1", int'(addr_vga), 41);
      if (n == 1 + 19*HT + 639)    chk("addr_r1c39", int'(addr_vga), 79);
      if (n == 1 + 20*HT)          chk("addr_vblank", int'(addr_vga), 0);
      if (n == 3 + 7*HT + 7)       chk("dot_center", int'(rgb), 'hFF);
      if (n == 3 + 5*HT + 7)       chk("dot_edge", int'(rgb), 'h00);
      if (n == 3 + 20)             chk("wall", int'(rgb), 'h03);
      if (n == 3 + 7*HT + 32)      chk("door_row7", int'(rgb), 'hF3);
      if (n == 3 + 6*HT + 32)      chk("door_row6", int'(rgb), 'h00);
      if (n == 3 + 22*HT)          chk("vsync_start", int'(vsync), 0);
      if (n == 3 + 24*HT)          chk("vsync_end", int'(vsync), 1);
      if (n == 3 + VV*HT)          chk("tick_literal", int'(frame_tick), 1);
    end
    chk("addr_vga", int'(addr_vga), ea);
    chk("rgb", int'(rgb), er);
    chk("hsync", int'(hsync), eh);
    chk("vsync", int'(vsync), ev);
    chk("blank", int'(blank), eb);
    chk("frame_tick", int'(frame_tick), ef);
  end

  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = 3'($urandom_range(7, 0));
    mem[0] = 3'd2; mem[1] = 3'd1; mem[2] = 3'd6; mem[3] = 3'd3;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    // Run two full frames and stop inside the third at hc=300, vc=10.
    repeat (2*FRAME + 10*HT + 300) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_rgb", int'(rgb), 0);
    chk("midrst_hsync", int'(hsync), 1);
    chk("midrst_vsync", int'(vsync), 1);
    chk("midrst_blank", int'(blank), 1);
    chk("midrst_tick", int'(frame_tick), 0);
    chk("midrst_addr", int'(addr_vga), 0);
    chk("ticks_two_frames", tick_cnt, 2);
    if (tick_cnt >= 2) chk("tick_period", tick_t[1] - tick_t[0], FRAME);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (3 + VV*HT + 100) @(posedge clk);
    @(negedge clk);
    chk("ticks_after_reset", tick_cnt, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
